// File: rtl/host_sq_responder.sv
`default_nettype none
// ============================================================================
// Module   : host_sq_responder
// Purpose  : Host-side responder for the user-logic descriptor interface.
//            Serves sq_rd/sq_wr requests from an internal 512-bit dual-port
//            memory over host stream 0 and returns cq_rd/cq_wr completions.
// Options  : HOST_RSP_STATS_EN adds stat_rd_cnt/stat_wr_cnt counters.
// Revision : 1.0 - initial release
// ============================================================================
module host_sq_responder #(
  parameter int MEM_DEPTH = 1024,
  parameter int N_STRM    = 1
) (
  input  logic                         aclk,
  input  logic                         areset,
  // read requests
  input  logic                         sq_rd_valid,
  output logic                         sq_rd_ready,
  input  logic [47:0]                  sq_rd_vaddr,
  input  logic [27:0]                  sq_rd_len,
  input  logic [5:0]                   sq_rd_pid,
  input  logic [3:0]                   sq_rd_dest,
  // write requests
  input  logic                         sq_wr_valid,
  output logic                         sq_wr_ready,
  input  logic [47:0]                  sq_wr_vaddr,
  input  logic [27:0]                  sq_wr_len,
  input  logic [5:0]                   sq_wr_pid,
  input  logic [3:0]                   sq_wr_dest,
  // read completions
  output logic                         cq_rd_valid,
  input  logic                         cq_rd_ready,
  output logic [5:0]                   cq_rd_pid,
  output logic [3:0]                   cq_rd_dest,
  // write completions
  output logic                         cq_wr_valid,
  input  logic                         cq_wr_ready,
  output logic [5:0]                   cq_wr_pid,
  output logic [3:0]                   cq_wr_dest,
  // read data towards user logic
  output logic [N_STRM-1:0]            axis_host_recv_tvalid,
  input  logic [N_STRM-1:0]            axis_host_recv_tready,
  output logic [N_STRM-1:0][511:0]     axis_host_recv_tdata,
  output logic [N_STRM-1:0][63:0]      axis_host_recv_tkeep,
  output logic [N_STRM-1:0]            axis_host_recv_tlast,
  output logic [N_STRM-1:0][3:0]       axis_host_recv_tid,
  // write data from user logic
  input  logic [N_STRM-1:0]            axis_host_send_tvalid,
  output logic [N_STRM-1:0]            axis_host_send_tready,
  input  logic [N_STRM-1:0][511:0]     axis_host_send_tdata,
  input  logic [N_STRM-1:0][63:0]      axis_host_send_tkeep,
  input  logic [N_STRM-1:0]            axis_host_send_tlast,
  input  logic [N_STRM-1:0][3:0]       axis_host_send_tid
`ifdef HOST_RSP_STATS_EN
  ,
  output logic [31:0]                  stat_rd_cnt,
  output logic [31:0]                  stat_wr_cnt
`endif
);

  localparam int c_AW = $clog2(MEM_DEPTH);

  // Number of 64-byte beats needed to carry len bytes.
  function automatic logic [22:0] beat_cnt(input logic [27:0] len);
    logic [28:0] sum;
    sum = {1'b0, len} + 29'd63;
    return sum[28:6];
  endfunction

  // Byte mask of the final beat: the low len%64 bytes, or all when aligned.
  function automatic logic [63:0] tail_keep(input logic [27:0] len);
    logic [63:0] mask;
    if (len[5:0] == 6'd0) mask = '1;
    else                  mask = (64'd1 << len[5:0]) - 64'd1;
    return mask;
  endfunction

  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_STREAM, RD_ACK} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_ACK} wr_state_t;

  rd_state_t        r_rd_state, w_rd_next;
  wr_state_t        r_wr_state, w_wr_next;

  logic [c_AW-1:0]  r_rd_addr;
  logic [22:0]      r_rd_left;
  logic [63:0]      r_rd_keep;
  logic [5:0]       r_rd_pid;
  logic [3:0]       r_rd_dest;
  logic [c_AW-1:0]  r_wr_addr;
  logic [22:0]      r_wr_left;
  logic [5:0]       r_wr_pid;
  logic [3:0]       r_wr_dest;

  logic [511:0]     r_mem [MEM_DEPTH];
  logic [511:0]     r_mem_q;

  logic             w_rd_tvalid;
  logic             w_rd_fire;
  logic             w_rd_last;
  logic             w_mem_re;
  logic [c_AW-1:0]  w_mem_ra;
  logic             w_wr_tready;
  logic             w_wr_fire;

  assign w_rd_fire = (r_rd_state == RD_STREAM) && axis_host_recv_tready[0];
  assign w_rd_last = (r_rd_left == 23'd1);
  assign w_wr_fire = (r_wr_state == WR_DATA) && axis_host_send_tvalid[0];

  // The prefetch register is loaded in FETCH and refilled with the next word
  // on every accepted beat, so it holds steady while the sink stalls.
  assign w_mem_re = (r_rd_state == RD_FETCH) || w_rd_fire;
  assign w_mem_ra = (r_rd_state == RD_FETCH) ? r_rd_addr : r_rd_addr + c_AW'(1);

  // Read FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_rd_state <= RD_IDLE;
    else        r_rd_state <= w_rd_next;
  end

  // Read FSM next state and handshake outputs
  always_comb begin
    w_rd_next   = r_rd_state;
    sq_rd_ready = 1'b0;
    cq_rd_valid = 1'b0;
    w_rd_tvalid = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        sq_rd_ready = !areset;
        if (sq_rd_valid)
          w_rd_next = (sq_rd_len == 28'd0) ? RD_ACK : RD_FETCH;
      end
      RD_FETCH:  w_rd_next = RD_STREAM;
      RD_STREAM: begin
        w_rd_tvalid = 1'b1;
        if (w_rd_fire && w_rd_last) w_rd_next = RD_ACK;
      end
      RD_ACK: begin
        cq_rd_valid = 1'b1;
        if (cq_rd_ready) w_rd_next = RD_IDLE;
      end
      default: w_rd_next = RD_IDLE;
    endcase
  end

  // Read request capture and per-beat address/count stepping
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rd_addr <= '0;
      r_rd_left <= '0;
      r_rd_keep <= '0;
      r_rd_pid  <= '0;
      r_rd_dest <= '0;
    end else if (r_rd_state == RD_IDLE && sq_rd_valid) begin
      r_rd_addr <= sq_rd_vaddr[6 +: c_AW];
      r_rd_left <= beat_cnt(sq_rd_len);
      r_rd_keep <= tail_keep(sq_rd_len);
      r_rd_pid  <= sq_rd_pid;
      r_rd_dest <= sq_rd_dest;
    end else if (w_rd_fire) begin
      r_rd_addr <= r_rd_addr + c_AW'(1);
      r_rd_left <= r_rd_left - 23'd1;
    end
  end

  // Write FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_wr_state <= WR_IDLE;
    else        r_wr_state <= w_wr_next;
  end

  // Write FSM next state and handshake outputs
  always_comb begin
    w_wr_next   = r_wr_state;
    sq_wr_ready = 1'b0;
    cq_wr_valid = 1'b0;
    w_wr_tready = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        sq_wr_ready = !areset;
        if (sq_wr_valid)
          w_wr_next = (sq_wr_len == 28'd0) ? WR_ACK : WR_DATA;
      end
      WR_DATA: begin
        w_wr_tready = 1'b1;
        if (w_wr_fire && (r_wr_left == 23'd1 || axis_host_send_tlast[0]))
          w_wr_next = WR_ACK;
      end
      WR_ACK: begin
        cq_wr_valid = 1'b1;
        if (cq_wr_ready) w_wr_next = WR_IDLE;
      end
      default: w_wr_next = WR_IDLE;
    endcase
  end

  // Write request capture and per-beat address/count stepping
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_addr <= '0;
      r_wr_left <= '0;
      r_wr_pid  <= '0;
      r_wr_dest <= '0;
    end else if (r_wr_state == WR_IDLE && sq_wr_valid) begin
      r_wr_addr <= sq_wr_vaddr[6 +: c_AW];
      r_wr_left <= beat_cnt(sq_wr_len);
      r_wr_pid  <= sq_wr_pid;
      r_wr_dest <= sq_wr_dest;
    end else if (w_wr_fire) begin
      r_wr_addr <= r_wr_addr + c_AW'(1);
      r_wr_left <= r_wr_left - 23'd1;
    end
  end

  // Read-first dual-port array with byte-enabled writes; contents survive reset
  always_ff @(posedge aclk) begin
    if (w_mem_re) r_mem_q <= r_mem[w_mem_ra];
    if (w_wr_fire) begin
      for (int b = 0; b < 64; b++) begin
        if (axis_host_send_tkeep[0][b])
          r_mem[r_wr_addr][b*8 +: 8] <= axis_host_send_tdata[0][b*8 +: 8];
      end
    end
  end

  assign cq_rd_pid  = r_rd_pid;
  assign cq_rd_dest = r_rd_dest;
  assign cq_wr_pid  = r_wr_pid;
  assign cq_wr_dest = r_wr_dest;

  // Only stream 0 carries traffic; any further streams are held quiet.
  for (genvar s = 0; s < N_STRM; s++) begin : g_strm
    if (s == 0) begin : g_used
      assign axis_host_recv_tvalid[s] = w_rd_tvalid;
      assign axis_host_recv_tdata[s]  = r_mem_q;
      assign axis_host_recv_tkeep[s]  = w_rd_last ? r_rd_keep : '1;
      assign axis_host_recv_tlast[s]  = w_rd_tvalid && w_rd_last;
      assign axis_host_recv_tid[s]    = r_rd_dest;
      assign axis_host_send_tready[s] = w_wr_tready;
    end else begin : g_idle
      assign axis_host_recv_tvalid[s] = 1'b0;
      assign axis_host_recv_tdata[s]  = '0;
      assign axis_host_recv_tkeep[s]  = '0;
      assign axis_host_recv_tlast[s]  = 1'b0;
      assign axis_host_recv_tid[s]    = '0;
      assign axis_host_send_tready[s] = 1'b0;
    end
  end

  // Address bits outside the word index and the write-side tid carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{sq_rd_vaddr[5:0], sq_rd_vaddr[47:6+c_AW],
                         sq_wr_vaddr[5:0], sq_wr_vaddr[47:6+c_AW],
                         axis_host_send_tid};

`ifdef HOST_RSP_STATS_EN
  logic [31:0] r_stat_rd_cnt;
  logic [31:0] r_stat_wr_cnt;

  // Completion counters, one step per accepted ack, wrapping naturally
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_stat_rd_cnt <= '0;
      r_stat_wr_cnt <= '0;
    end else begin
      if (cq_rd_valid && cq_rd_ready) r_stat_rd_cnt <= r_stat_rd_cnt + 32'd1;
      if (cq_wr_valid && cq_wr_ready) r_stat_wr_cnt <= r_stat_wr_cnt + 32'd1;
    end
  end

  assign stat_rd_cnt = r_stat_rd_cnt;
  assign stat_wr_cnt = r_stat_wr_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_host_sq_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_sq_responder
// Purpose  : Randomized self-checking bench for host_sq_responder against a
//            word/byte-level memory model kept in the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_host_sq_responder;

  localparam int DEPTH = 64;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic         sq_rd_valid = 0, sq_rd_ready;
  logic [47:0]  sq_rd_vaddr = 0;
  logic [27:0]  sq_rd_len = 0;
  logic [5:0]   sq_rd_pid = 0;
  logic [3:0]   sq_rd_dest = 0;
  logic         sq_wr_valid = 0, sq_wr_ready;
  logic [47:0]  sq_wr_vaddr = 0;
  logic [27:0]  sq_wr_len = 0;
  logic [5:0]   sq_wr_pid = 0;
  logic [3:0]   sq_wr_dest = 0;
  logic         cq_rd_valid, cq_rd_ready = 0;
  logic [5:0]   cq_rd_pid;
  logic [3:0]   cq_rd_dest;
  logic         cq_wr_valid, cq_wr_ready = 0;
  logic [5:0]   cq_wr_pid;
  logic [3:0]   cq_wr_dest;
  logic         recv_tvalid, recv_tready = 0, recv_tlast;
  logic [511:0] recv_tdata;
  logic [63:0]  recv_tkeep;
  logic [3:0]   recv_tid;
  logic         send_tvalid = 0, send_tready, send_tlast = 0;
  logic [511:0] send_tdata = 0;
  logic [63:0]  send_tkeep = 0;
  logic [3:0]   send_tid = 0;
`ifdef HOST_RSP_STATS_EN
  logic [31:0]  stat_rd_cnt, stat_wr_cnt;
`endif

  host_sq_responder #(.MEM_DEPTH(DEPTH), .N_STRM(1)) dut (
    .aclk(aclk), .areset(areset),
    .sq_rd_valid(sq_rd_valid), .sq_rd_ready(sq_rd_ready), .sq_rd_vaddr(sq_rd_vaddr),
    .sq_rd_len(sq_rd_len), .sq_rd_pid(sq_rd_pid), .sq_rd_dest(sq_rd_dest),
    .sq_wr_valid(sq_wr_valid), .sq_wr_ready(sq_wr_ready), .sq_wr_vaddr(sq_wr_vaddr),
    .sq_wr_len(sq_wr_len), .sq_wr_pid(sq_wr_pid), .sq_wr_dest(sq_wr_dest),
    .cq_rd_valid(cq_rd_valid), .cq_rd_ready(cq_rd_ready), .cq_rd_pid(cq_rd_pid), .cq_rd_dest(cq_rd_dest),
    .cq_wr_valid(cq_wr_valid), .cq_wr_ready(cq_wr_ready), .cq_wr_pid(cq_wr_pid), .cq_wr_dest(cq_wr_dest),
    .axis_host_recv_tvalid(recv_tvalid), .axis_host_recv_tready(recv_tready),
    .axis_host_recv_tdata(recv_tdata), .axis_host_recv_tkeep(recv_tkeep),
    .axis_host_recv_tlast(recv_tlast), .axis_host_recv_tid(recv_tid),
    .axis_host_send_tvalid(send_tvalid), .axis_host_send_tready(send_tready),
    .axis_host_send_tdata(send_tdata), .axis_host_send_tkeep(send_tkeep),
    .axis_host_send_tlast(send_tlast), .axis_host_send_tid(send_tid)
`ifdef HOST_RSP_STATS_EN
    , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
  );

  logic [511:0] ref_mem [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;
  int rd_acks  = 0;
  int wr_acks  = 0;

  // Single comparison point: counts every check and reports mismatches
  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int widx(input logic [47:0] va, input int i);
    return int'(((va >> 6) + 48'(i)) % 48'(DEPTH));
  endfunction

  function automatic logic [63:0] tail_keep(input int len);
    logic [63:0] k;
    int r;
    r = len % 64;
    if (r == 0) r = 64;
    for (int b = 0; b < 64; b++) k[b] = (b < r);
    return k;
  endfunction

  task automatic do_reset();
    areset = 1'b1;
    sq_rd_valid = 0; sq_wr_valid = 0; cq_rd_ready = 0; cq_wr_ready = 0;
    recv_tready = 0; send_tvalid = 0;
    repeat (2) @(posedge aclk);
    #1;
    check_eq("rst_sq_rd_ready", sq_rd_ready, 0);
    check_eq("rst_sq_wr_ready", sq_wr_ready, 0);
    check_eq("rst_valids", {recv_tvalid, cq_rd_valid, cq_wr_valid}, 0);
    check_eq("rst_send_tready", send_tready, 0);
    areset = 1'b0;
    @(posedge aclk); #1;
    check_eq("idle_sq_ready", {sq_rd_ready, sq_wr_ready}, 2'b11);
`ifdef HOST_RSP_STATS_EN
    check_eq("rst_stats", {stat_rd_cnt, stat_wr_cnt}, 0);
`endif
    rd_acks = 0;
    wr_acks = 0;
  endtask

  task automatic do_write(input logic [47:0] va, input int len, input int last_at,
                          input bit rnd_keep, input bit bp, input int pre);
    int nb, nsend, sent, cyc;
    bit fire;
    logic [5:0] pid;
    logic [3:0] dest;
    logic [511:0] d;
    logic [63:0] k;
    pid = 6'($urandom); dest = 4'($urandom);
    nb = (len + 63) / 64;
    nsend = (last_at > 0 && last_at < nb) ? last_at : nb;
    sent = 0;
    d = rnd512();
    k = (nb == 1) ? tail_keep(len) : '1;
    if (rnd_keep) k = k & {$urandom, $urandom};
    if (pre > 0 && nsend > 0) begin
      send_tdata = d; send_tkeep = k; send_tlast = (nsend == 1); send_tvalid = 1;
      repeat (pre) begin
        @(posedge aclk); #1;
        check_eq("wr_idle_backpressure", send_tready, 0);
      end
    end
    sq_wr_vaddr = va; sq_wr_len = 28'(len); sq_wr_pid = pid; sq_wr_dest = dest; sq_wr_valid = 1;
    cyc = 0;
    while (!sq_wr_ready && cyc < 200) begin @(posedge aclk); #1; cyc++; end
    if (cyc >= 200) begin check_eq("wr_req_timeout", 0, 1); sq_wr_valid = 0; return; end
    @(posedge aclk); #1;
    sq_wr_valid = 0;
    if (nb == 0) begin
      check_eq("wr_len0_ack", cq_wr_valid, 1);
    end else begin
      check_eq("wr_tready_t1", send_tready, 1);
      cyc = 0;
      while (sent < nsend && cyc < 1000) begin
        send_tdata = d; send_tkeep = k; send_tlast = (sent == nsend - 1);
        if (!send_tvalid) send_tvalid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        fire = send_tvalid && send_tready;
        @(posedge aclk); #1; cyc++;
        if (fire) begin
          for (int b = 0; b < 64; b++)
            if (k[b]) ref_mem[widx(va, sent)][b*8 +: 8] = d[b*8 +: 8];
          sent++;
          send_tvalid = 0;
          d = rnd512();
          k = (sent == nb - 1) ? tail_keep(len) : '1;
          if (rnd_keep) k = k & {$urandom, $urandom};
        end
      end
      send_tvalid = 0; send_tlast = 0;
      check_eq("wr_beats", sent, nsend);
      check_eq("wr_ack_rise", cq_wr_valid, 1);
      check_eq("wr_tready_after", send_tready, 0);
    end
    cyc = 0; fire = 0;
    while (!fire && cyc < 100) begin
      cq_wr_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      fire = cq_wr_valid && cq_wr_ready;
      if (fire) begin
        check_eq("wr_ack_pid", cq_wr_pid, pid);
        check_eq("wr_ack_dest", cq_wr_dest, dest);
      end
      @(posedge aclk); #1; cyc++;
    end
    cq_wr_ready = 0;
    if (!fire) check_eq("wr_ack_timeout", 0, 1);
    else wr_acks++;
    check_eq("wr_ack_once", cq_wr_valid, 0);
    check_eq("wr_idle_ready", sq_wr_ready, 1);
  endtask

  task automatic do_read(input logic [47:0] va, input int len, input bit bp, input int abort_after);
    int nb, got, cyc;
    bit fire, held_v;
    logic [511:0] held;
    logic [5:0] pid;
    logic [3:0] dest;
    pid = 6'($urandom); dest = 4'($urandom);
    nb = (len + 63) / 64;
    got = 0; held_v = 0; held = '0;
    sq_rd_vaddr = va; sq_rd_len = 28'(len); sq_rd_pid = pid; sq_rd_dest = dest; sq_rd_valid = 1;
    cyc = 0;
    while (!sq_rd_ready && cyc < 200) begin @(posedge aclk); #1; cyc++; end
    if (cyc >= 200) begin check_eq("rd_req_timeout", 0, 1); sq_rd_valid = 0; return; end
    @(posedge aclk); #1;
    sq_rd_valid = 0;
    if (nb == 0) begin
      check_eq("rd_len0_ack", cq_rd_valid, 1);
      check_eq("rd_len0_nobeat", recv_tvalid, 0);
    end else begin
      check_eq("rd_fetch_quiet", recv_tvalid, 0);
      @(posedge aclk); #1;
      check_eq("rd_first_lat", recv_tvalid, 1);
      cyc = 0;
      while (got < nb && cyc < 1000) begin
        recv_tready = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
        if (held_v) begin
          check_eq("rd_stall_valid", recv_tvalid, 1);
          check_eq("rd_stall_data", recv_tdata, held);
        end
        fire = recv_tvalid && recv_tready;
        if (fire) begin
          check_eq("rd_data", recv_tdata, ref_mem[widx(va, got)]);
          check_eq("rd_keep", recv_tkeep, (got == nb - 1) ? tail_keep(len) : 64'hFFFF_FFFF_FFFF_FFFF);
          check_eq("rd_last", recv_tlast, (got == nb - 1));
          check_eq("rd_tid", recv_tid, dest);
          held_v = 0;
        end else if (recv_tvalid) begin
          held_v = 1;
          held = recv_tdata;
        end
        @(posedge aclk); #1; cyc++;
        if (fire) begin
          got++;
          if (abort_after > 0 && got == abort_after) break;
        end
      end
      if (abort_after > 0) begin
        check_eq("abort_pre_tvalid", recv_tvalid, 1);
        #1 areset = 1'b1;
        #1;
        check_eq("abort_tvalid_low", recv_tvalid, 0);
        check_eq("abort_cq_low", cq_rd_valid, 0);
        do_reset();
        return;
      end
      recv_tready = 0;
      check_eq("rd_beats", got, nb);
      check_eq("rd_ack_rise", cq_rd_valid, 1);
      check_eq("rd_no_extra_beat", recv_tvalid, 0);
    end
    cyc = 0; fire = 0;
    while (!fire && cyc < 100) begin
      cq_rd_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      fire = cq_rd_valid && cq_rd_ready;
      if (fire) begin
        check_eq("rd_ack_pid", cq_rd_pid, pid);
        check_eq("rd_ack_dest", cq_rd_dest, dest);
      end
      @(posedge aclk); #1; cyc++;
    end
    cq_rd_ready = 0;
    if (!fire) check_eq("rd_ack_timeout", 0, 1);
    else rd_acks++;
    check_eq("rd_ack_once", cq_rd_valid, 0);
    check_eq("rd_idle_ready", sq_rd_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    do_reset();
    // fill the whole memory so every later read has a known reference
    do_write(48'h0, DEPTH * 64, 0, 0, 0, 0);
    // two-beat write then read back
    do_write(48'h0, 128, 0, 0, 0, 0);
    do_read(48'h0, 128, 0, 0);
    // partial tail and empty reads
    do_read(48'h140, 100, 0, 0);
    do_read(48'h200, 0, 0, 0);
    do_write(48'h300, 0, 0, 0, 0, 0);
    // address wrap at the top of memory
    do_read(48'((DEPTH - 1) * 64), 192, 0, 0);
    // 16-beat read under random backpressure
    do_read(48'h100, 1024, 1, 0);
    // beat presented while idle stays pending for the next write
    do_write(48'h5C0, 130, 0, 1, 1, 3);
    do_read(48'h5C0, 130, 0, 0);
    // concurrent read and early-tlast write from a fresh reset
    do_reset();
    fork
      do_read(48'h400, 512, 0, 0);
      do_write(48'hA00, 256, 1, 0, 0, 0);
    join
    do_read(48'hA00, 256, 0, 0);
`ifdef HOST_RSP_STATS_EN
    check_eq("stat_rd_after", stat_rd_cnt, 2);
    check_eq("stat_wr_after", stat_wr_cnt, 1);
`endif
    // reset in the middle of an 8-beat read, then a clean read
    do_read(48'h800, 512, 0, 3);
    do_read(48'h800, 512, 0, 0);
    // randomized mix of reads and writes
    for (int n = 0; n < 30; n++) begin
      logic [47:0] va;
      int len;
      va = {16'($urandom), 32'($urandom)};
      len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 600));
      if ($urandom_range(0, 1) == 1)
        do_write(va, len, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      else
        do_read(va, len, 1'($urandom_range(0, 1)), 0);
    end
`ifdef HOST_RSP_STATS_EN
    check_eq("stat_rd_final", stat_rd_cnt, rd_acks);
    check_eq("stat_wr_final", stat_wr_cnt, wr_acks);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
